fireball: RTL and testbench
===========================

Name: fireball

Overview:
- Projectile engine for one player. Sits directly downstream of the player block.
- Consumes the player block's x, y, state, direction and fireball_enable.
- Spawns a fireball, moves it one step per frame tick, and detects contact with the opponent.
- Its hit output drives the opponent player block's opponent_fireball input. Two instances exist, one per player.

Parameters:
- SPEED, 2, pixels moved per frame tick while in flight.
- SPAWN_OFFSET, 6, horizontal distance from the owner's x to the spawn position.
- Y_OFFSET, 4, spawn y = owner_y - Y_OFFSET.
- X_MIN, 1, left screen bound.
- X_MAX, 127, right screen bound.
- HIT_HALF_WIDTH, 4, maximum |fb_x - opp_x| that counts as a hit.
- HIT_HOLD_TICKS, 8, frame ticks that hit stays asserted.
- COOLDOWN_TICKS, 32, frame ticks after a fireball ends before the next launch is allowed.
- CLASH_DIST, 3, maximum |fb_x - opp_fb_x| that counts as a clash (only with FIREBALL_CLASH_EN).

Ports:
- clk  in  1  system clock
- start  in  1  asynchronous active-high reset (round start)
- frame_tick  in  1  one-cycle game-step enable
- fire  in  1  owner's fireball_enable, level-sensitive
- owner_x  in  10  owner x position
- owner_y  in  10  owner y position
- owner_state  in  3  owner state code
- owner_dir  in  1  owner facing: 0 = left, 1 = right
- opp_x  in  10  opponent x position
- opp_state  in  3  opponent state code
- opp_fb_active  in  1  opponent's fb_active
- opp_fb_x  in  10  opponent's fb_x
- fb_active  out  1  fireball is visible / in flight
- fb_x  out  10  fireball x position
- fb_y  out  10  fireball y position
- fb_dir  out  1  direction of travel
- hit  out  1  contact pulse-train, drives the opponent's opponent_fireball
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: clk is the only clock. start is asynchronous and active-high.
  - Asserting start clears everything, including mid-flight, mid-hit and mid-cooldown.
  - Reset values: state = IDLE; fb_active, hit, busy, fb_dir = 0; fb_x, fb_y, counters, fire_q = 0.
- State advance: all state advance is qualified by frame_tick. fire is edge-detected by sampling once per tick (fire_q).
- A launch request is: fire=1 and fire_q=0 on a tick.
- IDLE:
  - A launch request is accepted only when owner_state is DEFAULT_STATE or CROUCH_STATE.
  - On accept, latch fb_dir = owner_dir.
  - fb_x = owner_x + SPAWN_OFFSET, saturated to X_MAX (right); or owner_x - SPAWN_OFFSET, saturated to X_MIN (left).
  - fb_y = owner_y - Y_OFFSET.
  - Go to FLIGHT; fb_active rises on the same tick.
  - Requests while not IDLE are dropped, not queued.
- FLIGHT, evaluated each tick in priority order:
  1. Hit test: |fb_x - opp_x| <= HIT_HALF_WIDTH and opp_state != JUMP_STATE. Jumping dodges the fireball. The test uses a 10-bit unsigned absolute difference. On a hit: go to HIT_HOLD, hit=1, fb_active=0, counter=0.
  2. Clash test: only when FIREBALL_CLASH_EN is defined.
  3. Edge exit: going right and fb_x + SPEED > X_MAX, or going left and fb_x < X_MIN + SPEED. On exit: go to COOLDOWN, fb_active=0.
  4. Otherwise step fb_x by ±SPEED.
- Hit and edge on the same tick: the hit wins.
- HIT_HOLD: hit stays 1 for exactly HIT_HOLD_TICKS ticks, then hit=0 and go to COOLDOWN with counter=0.
- COOLDOWN: count COOLDOWN_TICKS ticks, then return to IDLE.
  - A fire edge on the tick IDLE is entered is ignored.
  - fire must be released and re-pressed to launch again.
- Owner changes: owner changes after launch (movement, getting hit) do not affect a fireball in flight.
- Output registers: fb_x and fb_y hold their last value when fb_active=0.
- Ticks: no action on cycles without frame_tick.

Optional Feature:
- FIREBALL_CLASH_EN defined:
  - In FLIGHT, clash condition: opp_fb_active=1 and |fb_x - opp_fb_x| <= CLASH_DIST.
  - On a clash: go to COOLDOWN with fb_active=0 and no hit.
  - Both instances see the symmetric condition on the same tick, so both cancel together.
- Undefined: opp_fb_active and opp_fb_x are ignored, and fireballs pass through each other.

Decomposition:
- globals.svh holds the state codes (DEFAULT_STATE, CROUCH_STATE, JUMP_STATE, HIT_STATE), LEFT/RIGHT, and screen bounds.
- globals.svh also gains the fireball FSM encoding: IDLE, FLIGHT, HIT_HOLD, COOLDOWN.
- One natural combinational sub-module, fireball_hitbox: absolute-difference compare, used for both the hit and clash tests.

Test Plan:
- Launch right: owner_x=10, owner_y=100, dir=1, DEFAULT_STATE, fire 0→1 on a tick -> fb_active=1, fb_x=16, fb_y=96; after 3 more ticks fb_x=22.
- Hit: opp_x=30, opp_state=DEFAULT, fireball flying right from 16 -> hit rises on the tick fb_x=26 is evaluated; stays high 8 ticks; busy=1 for 8+32 ticks after the hit rises; launch accepted only after a fresh edge.
- Dodge and exit: opp_state=JUMP_STATE for the whole flight -> no hit; at fb_x=126 goes to COOLDOWN, fb_active=0, fb_x holds 126.
- Blocked and held launches: owner_state=JUMP_STATE at fire edge -> no launch. fire held high through COOLDOWN end -> no relaunch until fire drops and rises.
- Reset mid-flight: start asserted between clock edges while fb_active=1 -> fb_active, hit, busy go to 0 immediately; launch works after start deasserts.
- Clash (FIREBALL_CLASH_EN): P1 at fb_x=60 going right, P2 at fb_x=62 going left, same tick -> both fb_active=0, hit=0 on both, both busy.

Source files
------------

// File: rtl/fireball_pkg.sv
// rtl/fireball_pkg.sv - shared codes, bounds and tuning constants for the fireball engine
// Contents: owner/opponent state codes, facing codes, screen bounds, motion and timing
// constants, and the fireball FSM encoding. Imported by fireball and fireball_hitbox.
package fireball_pkg;

    // Player state codes, as produced by the player block
    localparam logic [2:0] DEFAULT_STATE = 3'd0;
    localparam logic [2:0] CROUCH_STATE  = 3'd1;
    localparam logic [2:0] JUMP_STATE    = 3'd2;
    localparam logic [2:0] HIT_STATE     = 3'd3;

    // Facing / travel direction
    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    // Screen bounds and motion, all in 10-bit pixel space
    localparam logic [9:0] X_MIN          = 10'd1;
    localparam logic [9:0] X_MAX          = 10'd127;
    localparam logic [9:0] SPEED          = 10'd2;
    localparam logic [9:0] SPAWN_OFFSET   = 10'd6;
    localparam logic [9:0] Y_OFFSET       = 10'd4;
    localparam logic [9:0] HIT_HALF_WIDTH = 10'd4;
    localparam logic [9:0] CLASH_DIST     = 10'd3;

    // Tick counts and the shared down-stage counter
    localparam int HIT_HOLD_TICKS = 8;
    localparam int COOLDOWN_TICKS = 32;
    localparam int CNT_W          = 6;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HIT_HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLIGHT   = 2'd1,
        HIT_HOLD = 2'd2,
        COOLDOWN = 2'd3
    } fb_state_e;

endpackage

// File: rtl/fireball_hitbox.sv
// rtl/fireball_hitbox.sv - combinational unsigned absolute-difference proximity test
// Ports: a_i, b_i (positions), within_o (1 when |a_i - b_i| <= LIMIT).
module fireball_hitbox #(
    parameter int              WIDTH = 10,
    parameter logic [WIDTH-1:0] LIMIT = '0
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             within_o
);

    logic [WIDTH-1:0] diff;

    // Subtract the smaller from the larger so the difference never wraps
    assign diff     = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
    assign within_o = (diff <= LIMIT);

endmodule

// File: rtl/fireball.sv
// rtl/fireball.sv - per-player projectile engine: spawn, flight, hit hold, cooldown
// Inputs: clk, start (async reset), frame_tick, fire, owner_x/y/state/dir,
//         opp_x, opp_state, opp_fb_active, opp_fb_x.
// Outputs: fb_active, fb_x, fb_y, fb_dir, hit (to opponent), busy.
// Build option: FIREBALL_CLASH_EN makes two opposing fireballs cancel on contact.
module fireball
    import fireball_pkg::*;
(
    input  logic       clk,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       fire,
    input  logic [9:0] owner_x,
    input  logic [9:0] owner_y,
    input  logic [2:0] owner_state,
    input  logic       owner_dir,
    input  logic [9:0] opp_x,
    input  logic [2:0] opp_state,
    input  logic       opp_fb_active,
    input  logic [9:0] opp_fb_x,
    output logic       fb_active,
    output logic [9:0] fb_x,
    output logic [9:0] fb_y,
    output logic       fb_dir,
    output logic       hit,
    output logic       busy
);

    fb_state_e        state_q, state_d;
    logic [9:0]       fb_x_q, fb_x_d;
    logic [9:0]       fb_y_q, fb_y_d;
    logic             fb_dir_q, fb_dir_d;
    logic             fb_active_q, fb_active_d;
    logic             hit_q, hit_d;
    logic             fire_q, fire_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        near_opp;
    logic        clash;
    logic        launch_req;
    logic        can_launch;
    logic        at_edge;
    logic [10:0] right_spawn;

    fireball_hitbox #(.WIDTH(10), .LIMIT(HIT_HALF_WIDTH)) u_hit_box (
        .a_i      (fb_x_q),
        .b_i      (opp_x),
        .within_o (near_opp)
    );

`ifdef FIREBALL_CLASH_EN
    logic near_opp_fb;

    fireball_hitbox #(.WIDTH(10), .LIMIT(CLASH_DIST)) u_clash_box (
        .a_i      (fb_x_q),
        .b_i      (opp_fb_x),
        .within_o (near_opp_fb)
    );

    assign clash = opp_fb_active & near_opp_fb;
`else
    logic unused_opp_fb;

    assign unused_opp_fb = &{1'b0, opp_fb_active, opp_fb_x};
    assign clash         = 1'b0;
`endif

    // Rising edge of fire as seen on successive ticks; a held button never relaunches
    assign launch_req  = fire & ~fire_q;
    assign can_launch  = (owner_state == DEFAULT_STATE) || (owner_state == CROUCH_STATE);
    assign right_spawn = {1'b0, owner_x} + {1'b0, SPAWN_OFFSET};
    // Widened compare on the right so fb_x + SPEED cannot wrap
    assign at_edge     = fb_dir_q ? (({1'b0, fb_x_q} + {1'b0, SPEED}) > {1'b0, X_MAX})
                                  : (fb_x_q < (X_MIN + SPEED));

    always_comb begin
        state_d     = state_q;
        fb_x_d      = fb_x_q;
        fb_y_d      = fb_y_q;
        fb_dir_d    = fb_dir_q;
        fb_active_d = fb_active_q;
        hit_d       = hit_q;
        fire_d      = fire_q;
        cnt_d       = cnt_q;

        if (frame_tick) begin
            fire_d = fire;
            case (state_q)
                IDLE: begin
                    if (launch_req && can_launch) begin
                        fb_dir_d    = owner_dir;
                        fb_y_d      = owner_y - Y_OFFSET;
                        fb_active_d = 1'b1;
                        state_d     = FLIGHT;
                        if (owner_dir == RIGHT) begin
                            fb_x_d = (right_spawn > {1'b0, X_MAX}) ? X_MAX : right_spawn[9:0];
                        end else begin
                            fb_x_d = (owner_x < (X_MIN + SPAWN_OFFSET)) ? X_MIN
                                                                         : (owner_x - SPAWN_OFFSET);
                        end
                    end
                end
                FLIGHT: begin
                    // Hit outranks clash and edge exit; a jumping opponent dodges
                    if (near_opp && (opp_state != JUMP_STATE)) begin
                        state_d     = HIT_HOLD;
                        hit_d       = 1'b1;
                        fb_active_d = 1'b0;
                        cnt_d       = '0;
                    end else if (clash || at_edge) begin
                        state_d     = COOLDOWN;
                        fb_active_d = 1'b0;
                        cnt_d       = '0;
                    end else begin
                        fb_x_d = fb_dir_q ? (fb_x_q + SPEED) : (fb_x_q - SPEED);
                    end
                end
                HIT_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        hit_d   = 1'b0;
                        state_d = COOLDOWN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (cnt_q == COOL_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            state_q     <= IDLE;
            fb_x_q      <= '0;
            fb_y_q      <= '0;
            fb_dir_q    <= 1'b0;
            fb_active_q <= 1'b0;
            hit_q       <= 1'b0;
            fire_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            fb_x_q      <= fb_x_d;
            fb_y_q      <= fb_y_d;
            fb_dir_q    <= fb_dir_d;
            fb_active_q <= fb_active_d;
            hit_q       <= hit_d;
            fire_q      <= fire_d;
            cnt_q       <= cnt_d;
        end
    end

    assign fb_active = fb_active_q;
    assign fb_x      = fb_x_q;
    assign fb_y      = fb_y_q;
    assign fb_dir    = fb_dir_q;
    assign hit       = hit_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fireball.sv
// tb/tb_fireball.sv - self-checking bench for fireball against a tick-level reference model
module tb_fireball;
    import fireball_pkg::*;

    logic       clk = 1'b0;
    logic       start = 1'b1;
    logic       frame_tick = 1'b0;
    logic       fire = 1'b0;
    logic [9:0] owner_x = '0;
    logic [9:0] owner_y = '0;
    logic [2:0] owner_state = DEFAULT_STATE;
    logic       owner_dir = 1'b0;
    logic [9:0] opp_x = '0;
    logic [2:0] opp_state = DEFAULT_STATE;
    logic       opp_fb_active = 1'b0;
    logic [9:0] opp_fb_x = '0;
    logic       fb_active;
    logic [9:0] fb_x;
    logic [9:0] fb_y;
    logic       fb_dir;
    logic       hit;
    logic       busy;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 waiting, 1 flying, 2 hit shown, 3 recovering.
    // m_left counts the ticks still to spend in modes 2 and 3.
    int m_mode;
    int m_x;
    int m_y;
    int m_left;
    int m_dir;
    int m_act;
    int m_hit;
    int m_fire_prev;

    fireball dut (
        .clk           (clk),
        .start         (start),
        .frame_tick    (frame_tick),
        .fire          (fire),
        .owner_x       (owner_x),
        .owner_y       (owner_y),
        .owner_state   (owner_state),
        .owner_dir     (owner_dir),
        .opp_x         (opp_x),
        .opp_state     (opp_state),
        .opp_fb_active (opp_fb_active),
        .opp_fb_x      (opp_fb_x),
        .fb_active     (fb_active),
        .fb_x          (fb_x),
        .fb_y          (fb_y),
        .fb_dir        (fb_dir),
        .hit           (hit),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_x = 0; m_y = 0; m_left = 0;
        m_dir = 0; m_act = 0; m_hit = 0; m_fire_prev = 0;
    endtask

    task automatic model_tick();
        int pressed;
        pressed     = (fire == 1'b1 && m_fire_prev == 0) ? 1 : 0;
        m_fire_prev = int'(fire);
        case (m_mode)
            0: begin
                if (pressed == 1 && (owner_state == DEFAULT_STATE || owner_state == CROUCH_STATE)) begin
                    m_dir = int'(owner_dir);
                    if (m_dir == 1) m_x = (int'(owner_x) + 6 > 127) ? 127 : int'(owner_x) + 6;
                    else            m_x = (int'(owner_x) - 6 < 1) ? 1 : int'(owner_x) - 6;
                    m_y    = (int'(owner_y) - 4 + 1024) % 1024;
                    m_act  = 1;
                    m_mode = 1;
                end
            end
            1: begin
                if (iabs(m_x - int'(opp_x)) <= 4 && opp_state != JUMP_STATE) begin
                    m_mode = 2; m_hit = 1; m_act = 0; m_left = 8;
`ifdef FIREBALL_CLASH_EN
                end else if (opp_fb_active == 1'b1 && iabs(m_x - int'(opp_fb_x)) <= 3) begin
                    m_mode = 3; m_act = 0; m_left = 32;
`endif
                end else if ((m_dir == 1 && m_x + 2 > 127) || (m_dir == 0 && m_x < 3)) begin
                    m_mode = 3; m_act = 0; m_left = 32;
                end else begin
                    m_x = (m_dir == 1) ? m_x + 2 : m_x - 2;
                end
            end
            2: begin
                m_left--;
                if (m_left == 0) begin
                    m_hit = 0; m_mode = 3; m_left = 32;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        check("fb_active", int'(fb_active), m_act);
        check("hit", int'(hit), m_hit);
        check("busy", int'(busy), (m_mode != 0) ? 1 : 0);
        check("fb_x", int'(fb_x), m_x);
        check("fb_y", int'(fb_y), m_y);
        check("fb_dir", int'(fb_dir), m_dir);
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic cycle(input bit t);
        frame_tick = t;
        @(posedge clk);
        if (t) model_tick();
        #1;
        compare_all();
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        start      = 1'b1;
        frame_tick = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic press();
        fire = 1'b0;
        cycle(1'b1);
        fire = 1'b1;
        cycle(1'b1);
    endtask

    initial begin
        int n;
        int hit_n;

        model_reset();
        do_reset();

        // Launch right and hit a standing opponent
        owner_x = 10'd10; owner_y = 10'd100; owner_dir = RIGHT; owner_state = DEFAULT_STATE;
        opp_x = 10'd30; opp_state = DEFAULT_STATE;
        press();
        check("spawn_x", int'(fb_x), 16);
        check("spawn_y", int'(fb_y), 96);
        check("spawn_active", int'(fb_active), 1);
        cycle(1'b0);
        repeat (3) cycle(1'b1);
        check("flight_x", int'(fb_x), 22);
        repeat (2) cycle(1'b1);
        check("pre_hit", int'(hit), 0);
        cycle(1'b1);
        check("hit_rise", int'(hit), 1);
        check("hit_fb_off", int'(fb_active), 0);
        n = 0; hit_n = 1;
        while (busy && n < 100) begin
            cycle(1'b1);
            n++;
            if (hit) hit_n++;
        end
        check("busy_ticks", n, 40);
        check("hit_ticks", hit_n, 8);
        cycle(1'b1);
        check("held_fire_no_launch", int'(fb_active), 0);
        press();
        check("relaunch", int'(fb_active), 1);

        // Dodge by jumping, then leave at the right edge
        do_reset();
        opp_state = JUMP_STATE; opp_x = 10'd60;
        press();
        n = 0;
        while (fb_active && n < 200) begin
            cycle(1'b1);
            n++;
        end
        check("dodge_ticks", n, 56);
        check("exit_x_hold", int'(fb_x), 126);
        check("exit_busy", int'(busy), 1);

        // Launch blocked while the owner is jumping
        do_reset();
        owner_state = JUMP_STATE;
        press();
        check("blocked_launch", int'(fb_active), 0);
        check("blocked_busy", int'(busy), 0);

        // Asynchronous reset mid-flight
        owner_state = CROUCH_STATE; opp_x = 10'd500;
        press();
        repeat (3) cycle(1'b1);
        check("pre_reset_active", int'(fb_active), 1);
        #2 start = 1'b1;
        #1;
        check("rst_fb_active", int'(fb_active), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_busy", int'(busy), 0);
        model_reset();
        @(negedge clk);
        start = 1'b0;
        press();
        check("post_reset_launch", int'(fb_active), 1);

        // Randomized play
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 3) == 0) fire = ~fire;
                owner_x       = 10'($urandom_range(0, 140));
                owner_y       = 10'($urandom_range(0, 1023));
                owner_dir     = 1'($urandom_range(0, 1));
                owner_state   = 3'($urandom_range(0, 4));
                opp_x         = 10'($urandom_range(0, 140));
                opp_state     = 3'($urandom_range(0, 4));
                opp_fb_active = 1'($urandom_range(0, 1));
                opp_fb_x      = 10'($urandom_range(0, 140));
                cycle(1'($urandom_range(0, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
